// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM encoding, width defaults
// and the values loaded into the MEM/WB bundle when it carries a bubble.
package mem_access_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 5;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic       BUBBLE_WRITE   = 1'b0;
  localparam logic [1:0] BUBBLE_QUARTER = 2'b00;

endpackage

// File: rtl/mem_access_stage_wb_reg.sv
// MEM/WB register bank: loads the write-back bundle when enabled, or a bubble
// (all fields cleared, write disabled) when the bubble select is set.
module mem_wb_out_reg
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_write,
  input  logic [REG_W-1:0]  i_writeReg,
  input  logic [1:0]        i_quarter,
  output logic [DATA_W-1:0] o_WriteData,
  output logic              o_write,
  output logic [REG_W-1:0]  o_writeReg,
  output logic [1:0]        o_quarter
);

  // Bundle register: reset clears, load takes either the bundle or a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_WriteData <= {DATA_W{1'b0}};
      o_write     <= BUBBLE_WRITE;
      o_writeReg  <= {REG_W{1'b0}};
      o_quarter   <= BUBBLE_QUARTER;
    end else if (i_load) begin
      if (i_bubble) begin
        o_WriteData <= {DATA_W{1'b0}};
        o_write     <= BUBBLE_WRITE;
        o_writeReg  <= {REG_W{1'b0}};
        o_quarter   <= BUBBLE_QUARTER;
      end else begin
        o_WriteData <= i_data;
        o_write     <= i_write;
        o_writeReg  <= i_writeReg;
        o_quarter   <= i_quarter;
      end
    end else begin
      o_WriteData <= o_WriteData;
      o_write     <= o_write;
      o_writeReg  <= o_writeReg;
      o_quarter   <= o_quarter;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: RAM request/ack handshake with pipeline stall
// and a registered MEM/WB bundle. Define MEM_TIMEOUT_EN to enable the ack timeout.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_DataAddress,
  input  logic              i_ReadMem,
  input  logic              i_WriteMem,
  input  logic [1:0]        i_quarter,
  input  logic [DATA_W-1:0] i_DataIn,
  input  logic              i_write,
  input  logic [REG_W-1:0]  i_writeReg,
  output logic              ram_req,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] o_WriteData,
  output logic              o_write,
  output logic [REG_W-1:0]  o_writeReg,
  output logic [1:0]        o_quarter,
  output logic              mem_err
);

  logic [0:0]        r_state;
  logic              r_hold_write;
  logic [REG_W-1:0]  r_hold_reg;
  logic [1:0]        r_hold_quarter;

  logic              w_mem_op;
  logic              w_timeout;
  logic              w_wb_load;
  logic              w_wb_bubble;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_write;
  logic [REG_W-1:0]  w_wb_reg;
  logic [1:0]        w_wb_quarter;

  assign w_mem_op = i_ReadMem | i_WriteMem;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_err;

  // The abort fires in the ACK_TIMEOUT-th ACCESS cycle that sees no ack.
  assign w_timeout = (r_state == ST_ACCESS) && !ram_ack &&
                     (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign mem_err   = r_mem_err;

  // Ack-wait counter and one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_timeout;
      if (r_state == ST_IDLE) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (!ram_ack) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign mem_err   = (ACK_TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

  // FSM plus RAM request registers; the RAM-side registers double as the held request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      ram_req        <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= {DATA_W{1'b0}};
      ram_wdata      <= {DATA_W{1'b0}};
      r_hold_write   <= 1'b0;
      r_hold_reg     <= {REG_W{1'b0}};
      r_hold_quarter <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_op) begin
            r_state        <= ST_ACCESS;
            ram_req        <= 1'b1;
            ram_we         <= i_WriteMem;
            ram_addr       <= i_DataAddress;
            ram_wdata      <= i_DataIn;
            r_hold_write   <= i_write;
            r_hold_reg     <= i_writeReg;
            r_hold_quarter <= i_quarter;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (ram_ack || w_timeout) begin
            r_state <= ST_IDLE;
            ram_req <= 1'b0;
          end else begin
            r_state <= ST_ACCESS;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          ram_req <= 1'b0;
        end
      endcase
    end
  end

  // Stall and WB-bundle selection.
  always_comb begin
    stall        = 1'b0;
    w_wb_load    = 1'b0;
    w_wb_bubble  = 1'b0;
    w_wb_data    = i_DataAddress;
    w_wb_write   = i_write;
    w_wb_reg     = i_writeReg;
    w_wb_quarter = i_quarter;
    case (r_state)
      ST_IDLE: begin
        stall       = w_mem_op;
        w_wb_load   = 1'b1;
        w_wb_bubble = w_mem_op;
      end
      ST_ACCESS: begin
        stall        = !ram_ack && !w_timeout;
        w_wb_load    = ram_ack || w_timeout;
        w_wb_bubble  = w_timeout;
        w_wb_data    = ram_we ? ram_addr : ram_rdata;
        w_wb_write   = r_hold_write;
        w_wb_reg     = r_hold_reg;
        w_wb_quarter = r_hold_quarter;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  mem_wb_out_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_wb_reg (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_wb_load),
    .i_bubble    (w_wb_bubble),
    .i_data      (w_wb_data),
    .i_write     (w_wb_write),
    .i_writeReg  (w_wb_reg),
    .i_quarter   (w_wb_quarter),
    .o_WriteData (o_WriteData),
    .o_write     (o_write),
    .o_writeReg  (o_writeReg),
    .o_quarter   (o_quarter)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; the timeout scenario
// runs only when MEM_TIMEOUT_EN is defined (ACK_TIMEOUT overridden to 4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] i_DataAddress;
  logic        i_ReadMem;
  logic        i_WriteMem;
  logic [1:0]  i_quarter;
  logic [15:0] i_DataIn;
  logic        i_write;
  logic [4:0]  i_writeReg;
  logic        ram_req;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_ack;
  logic [15:0] ram_rdata;
  logic        stall;
  logic [15:0] o_WriteData;
  logic        o_write;
  logic [4:0]  o_writeReg;
  logic [1:0]  o_quarter;
  logic        mem_err;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .DATA_W      (16),
    .REG_W       (5),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_DataAddress (i_DataAddress),
    .i_ReadMem     (i_ReadMem),
    .i_WriteMem    (i_WriteMem),
    .i_quarter     (i_quarter),
    .i_DataIn      (i_DataIn),
    .i_write       (i_write),
    .i_writeReg    (i_writeReg),
    .ram_req       (ram_req),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_ack       (ram_ack),
    .ram_rdata     (ram_rdata),
    .stall         (stall),
    .o_WriteData   (o_WriteData),
    .o_write       (o_write),
    .o_writeReg    (o_writeReg),
    .o_quarter     (o_quarter),
    .mem_err       (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_DataAddress = 16'h0000; i_ReadMem = 1'b0; i_WriteMem = 1'b0;
    i_quarter = 2'b00; i_DataIn = 16'h0000; i_write = 1'b0; i_writeReg = 5'd0;
    ram_ack = 1'b0; ram_rdata = 16'h0000;
    tick(); tick();
    chk("rst_req", 32'(ram_req), 32'h0);
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_wdata", 32'(ram_wdata), 32'h0);
    chk("rst_wdata_out", 32'(o_WriteData), 32'h0);
    chk("rst_write", 32'(o_write), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    reset = 1'b0;

    // Non-memory pass-through
    i_DataAddress = 16'h1234; i_write = 1'b1; i_writeReg = 5'd3; i_quarter = 2'd2;
    #1 chk("pt_stall", 32'(stall), 32'h0);
    tick();
    chk("pt_data", 32'(o_WriteData), 32'h1234);
    chk("pt_write", 32'(o_write), 32'h1);
    chk("pt_reg", 32'(o_writeReg), 32'h3);
    chk("pt_quarter", 32'(o_quarter), 32'h2);
    chk("pt_stall2", 32'(stall), 32'h0);

    // Load, ack three edges after ram_req rises
    i_ReadMem = 1'b1; i_DataAddress = 16'h0040; i_writeReg = 5'd7; i_quarter = 2'd1; i_write = 1'b1;
    #1 chk("ld_stall0", 32'(stall), 32'h1);
    tick();
    i_ReadMem = 1'b0; i_DataAddress = 16'hDEAD; i_writeReg = 5'd0;
    chk("ld_req", 32'(ram_req), 32'h1);
    chk("ld_addr", 32'(ram_addr), 32'h0040);
    chk("ld_we", 32'(ram_we), 32'h0);
    chk("ld_bubble", 32'(o_write), 32'h0);
    chk("ld_stall1", 32'(stall), 32'h1);
    tick();
    chk("ld_stall2", 32'(stall), 32'h1);
    chk("ld_addr_hold", 32'(ram_addr), 32'h0040);
    tick();
    chk("ld_stall3", 32'(stall), 32'h1);
    tick();
    ram_ack = 1'b1; ram_rdata = 16'hBEEF;
    #1 chk("ld_stall_ack", 32'(stall), 32'h0);
    tick();
    ram_ack = 1'b0; ram_rdata = 16'h0000;
    chk("ld_req_drop", 32'(ram_req), 32'h0);
    chk("ld_data", 32'(o_WriteData), 32'hBEEF);
    chk("ld_write", 32'(o_write), 32'h1);
    chk("ld_reg", 32'(o_writeReg), 32'h7);
    chk("ld_quarter", 32'(o_quarter), 32'h1);

    // Store, wdata held while upstream changes
    i_WriteMem = 1'b1; i_DataAddress = 16'h0010; i_DataIn = 16'hA5A5; i_write = 1'b0;
    tick();
    i_WriteMem = 1'b0; i_DataIn = 16'hFFFF; i_DataAddress = 16'h0000;
    chk("st_we", 32'(ram_we), 32'h1);
    chk("st_wdata", 32'(ram_wdata), 32'hA5A5);
    chk("st_addr", 32'(ram_addr), 32'h0010);
    tick();
    chk("st_wdata_hold", 32'(ram_wdata), 32'hA5A5);
    chk("st_req_hold", 32'(ram_req), 32'h1);
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    chk("st_req_drop", 32'(ram_req), 32'h0);
    chk("st_write", 32'(o_write), 32'h0);
    chk("st_data", 32'(o_WriteData), 32'h0010);

    // Read+write together acts as store; ack in first ACCESS cycle
    i_ReadMem = 1'b1; i_WriteMem = 1'b1; i_DataAddress = 16'h0020; i_DataIn = 16'h1111; i_write = 1'b1;
    tick();
    i_ReadMem = 1'b0; i_WriteMem = 1'b0; i_write = 1'b0; i_DataAddress = 16'h0000;
    chk("both_we", 32'(ram_we), 32'h1);
    ram_ack = 1'b1; ram_rdata = 16'h9999;
    #1 chk("both_stall_ack", 32'(stall), 32'h0);
    tick();
    ram_ack = 1'b0;
    chk("both_req_drop", 32'(ram_req), 32'h0);
    chk("both_data", 32'(o_WriteData), 32'h0020);
    chk("both_write", 32'(o_write), 32'h1);

    // Ack in IDLE is ignored
    ram_ack = 1'b1; i_DataAddress = 16'h5555; i_write = 1'b1; i_writeReg = 5'd9;
    tick();
    ram_ack = 1'b0;
    chk("idle_ack_req", 32'(ram_req), 32'h0);
    chk("idle_ack_data", 32'(o_WriteData), 32'h5555);
    chk("idle_ack_reg", 32'(o_writeReg), 32'h9);

    // Reset during the second ACCESS cycle
    i_ReadMem = 1'b1; i_DataAddress = 16'h0080; i_write = 1'b1;
    tick();
    i_ReadMem = 1'b0; i_DataAddress = 16'h0000; i_write = 1'b0;
    tick();
    chk("rsta_req_before", 32'(ram_req), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rsta_req", 32'(ram_req), 32'h0);
    chk("rsta_write", 32'(o_write), 32'h0);
    chk("rsta_stall", 32'(stall), 32'h0);
    ram_ack = 1'b1; ram_rdata = 16'h7777;
    tick();
    ram_ack = 1'b0;
    chk("late_ack_req", 32'(ram_req), 32'h0);
    chk("late_ack_write", 32'(o_write), 32'h0);
    chk("late_ack_data", 32'(o_WriteData), 32'h0000);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 4 ACCESS cycles
    i_ReadMem = 1'b1; i_DataAddress = 16'h0100; i_write = 1'b1;
    tick();
    i_ReadMem = 1'b0; i_DataAddress = 16'h0000; i_write = 1'b0;
    chk("to_req1", 32'(ram_req), 32'h1);
    chk("to_stall1", 32'(stall), 32'h1);
    tick();
    chk("to_req2", 32'(ram_req), 32'h1);
    tick();
    chk("to_req3", 32'(ram_req), 32'h1);
    tick();
    chk("to_req4", 32'(ram_req), 32'h1);
    chk("to_stall4", 32'(stall), 32'h0);
    chk("to_err_early", 32'(mem_err), 32'h0);
    tick();
    chk("to_req_drop", 32'(ram_req), 32'h0);
    chk("to_err", 32'(mem_err), 32'h1);
    chk("to_write", 32'(o_write), 32'h0);
    chk("to_data", 32'(o_WriteData), 32'h0000);
    tick();
    chk("to_err_clear", 32'(mem_err), 32'h0);
`else
    chk("err_tied", 32'(mem_err), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer end of the EX/MEM interface: takes the latched EX/MEM bundle and performs the data-RAM access.
- Runs a request/acknowledge handshake to RAM and stalls the pipeline while the access is outstanding.
- Presents a registered MEM/WB bundle (write-back data, regfile write enable, destination register, quarter) to the write-back stage.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- DATA_W, 16, data and address width.
- REG_W, 5, regfile index width.
- ACK_TIMEOUT, 15, maximum ACCESS cycles before abort; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- i_DataAddress  in  DATA_W  ALU result / RAM address.
- i_ReadMem  in  1  load request.
- i_WriteMem  in  1  store request.
- i_quarter  in  2  regfile lane select, passed through.
- i_DataIn  in  DATA_W  store data.
- i_write  in  1  regfile write enable.
- i_writeReg  in  REG_W  destination register.
- ram_req  out  1  RAM request, level held until ack.
- ram_we  out  1  1 = store, 0 = load.
- ram_addr  out  DATA_W  RAM address.
- ram_wdata  out  DATA_W  RAM store data.
- ram_ack  in  1  single-cycle acknowledge from RAM.
- ram_rdata  in  DATA_W  load data, valid when ram_ack = 1.
- stall  out  1  freezes the upstream pipeline and the EX/MEM latch.
- o_WriteData  out  DATA_W  write-back value.
- o_write  out  1  regfile write enable to WB.
- o_writeReg  out  REG_W  destination register to WB.
- o_quarter  out  2  lane select to WB.
- mem_err  out  1  timeout pulse; tied 0 without the optional feature.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - ram_req, ram_we, ram_addr, ram_wdata = 0.
  - o_WriteData, o_write, o_writeReg, o_quarter = 0.
  - mem_err = 0; timeout counter = 0.
  - Reset during ACCESS abandons the access immediately: ram_req is 0 the next cycle and no WB write occurs.
- IDLE:
  - No memory op (i_ReadMem = i_WriteMem = 0): the WB registers load i_DataAddress, i_write, i_writeReg, i_quarter. One-cycle latency.
  - Memory op present:
    - Capture address, store data, ram_we (= i_WriteMem), write, writeReg and quarter into holding registers.
    - Set ram_req = 1 on the next edge and go to ACCESS.
    - The WB registers load a bubble (o_write = 0).
  - i_ReadMem and i_WriteMem both 1: treated as a store; the load is dropped.
- ACCESS:
  - ram_req, ram_we, ram_addr and ram_wdata stay stable; upstream inputs are ignored.
  - On ram_ack:
    - ram_req drops on the next edge.
    - The WB registers load from the holding registers; o_WriteData = ram_rdata for a load, the held address for a store.
    - o_write = held write.
    - Return to IDLE.
  - An ack that arrives in the first ACCESS cycle is legal, giving a minimum total memory-op latency of 2 cycles.
- stall is combinational: (IDLE and (i_ReadMem or i_WriteMem)) or (ACCESS and not ram_ack).
  - It therefore deasserts in the ack cycle, so the next instruction is accepted on the same edge that completes the access.
- ram_ack seen while in IDLE is ignored.
- Back-to-back memory ops: each one pays the full handshake; there is no pipelined RAM access.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches ACK_TIMEOUT:
    - ram_req drops.
    - mem_err pulses high for exactly 1 cycle.
    - The WB registers load a bubble (o_write = 0, o_WriteData = 0).
    - The FSM returns to IDLE and stall deasserts in that cycle.
- Without the macro: ACCESS waits indefinitely for ack, mem_err is constant 0, and no counter is synthesized.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE = 1'b0, ACCESS = 1'b1).
  - DATA_W and REG_W defaults.
  - Bubble constants.
- One natural sub-module, mem_wb_out_reg: the reset-capable register bank for the WB bundle, with a load-enable and a bubble select.

Test Plan:
- Reset, then i_ReadMem = 0, i_DataAddress = 16'h1234, i_write = 1, i_writeReg = 5'd3 -> one cycle later o_WriteData = 16'h1234, o_write = 1, o_writeReg = 3; stall stays 0.
- Load to address 16'h0040, RAM acks 3 cycles after ram_req rises with ram_rdata = 16'hBEEF -> ram_addr = 16'h0040, ram_we = 0; stall high 4 cycles; then o_WriteData = 16'hBEEF, o_write = 1.
- Store of 16'hA5A5 to 16'h0010 with i_write = 0 -> ram_we = 1, ram_wdata = 16'hA5A5 held until ack; o_write = 0 afterwards.
- Both i_ReadMem and i_WriteMem = 1 -> ram_we = 1.
- Reset asserted in the 2nd ACCESS cycle -> next cycle ram_req = 0, state IDLE, o_write = 0; a late ram_ack is ignored.
- With MEM_TIMEOUT_EN and ACK_TIMEOUT = 4, no ack -> ram_req drops after 4 ACCESS cycles, mem_err is a 1-cycle pulse, o_write = 0, stall releases.
